fifo_sync_flags: RTL and testbench

Parametrised single-clock FIFO: the next-generation storage block for the FIFO datapath, generalised in width and depth. It adds programmable almost-full/almost-empty thresholds, an occupancy count and overflow/underflow error pulses. Unlike the previous generation, which required `write_en` and `read_en` to be mutually exclusive, it accepts simultaneous read and write. It sits between a producer and a consumer in the same clock domain.

---
 rtl/fifo_sync_flags_if.sv | 26 ++
 rtl/fifo_sync_flags.sv | 66 ++++++
 tb/tb_fifo_sync_flags.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: producer/consumer handshake and status bundle for fifo_sync_flags.
interface fifo_sync_flags_if #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic                  write_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  read_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    modport master (
        output write_en, data_in, read_en,
        input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
    modport slave (
        input  write_en, data_in, read_en,
        output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with occupancy count, programmable almost flags and error pulses.
module fifo_sync_flags #(
    parameter int FIFO_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input logic clk,
    input logic rstN,
    fifo_sync_flags_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wp, r_rp;
    logic [CW-1:0]         r_count;
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_ovf, r_udf;
    logic                  w_full, w_empty, w_wr_ok, w_rd_ok;
    logic [PW-1:0]         w_wp_nxt, w_rp_nxt;
    logic [CW-1:0]         w_count_nxt;

    // A write is still accepted when full if a read frees a slot on the same edge.
    always_comb begin
        w_full      = r_count == CW'(FIFO_DEPTH);
        w_empty     = r_count == '0;
        w_wr_ok     = bus.write_en && (!w_full || bus.read_en);
        w_rd_ok     = bus.read_en && !w_empty;
        w_wp_nxt    = (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
        w_rp_nxt    = (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
        w_count_nxt = (w_wr_ok && !w_rd_ok) ? r_count + 1'b1 :
                      (w_rd_ok && !w_wr_ok) ? r_count - 1'b1 : r_count;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wp] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            if (w_wr_ok) r_wp <= w_wp_nxt;
            if (w_rd_ok) r_rp <= w_rp_nxt;
            if (w_rd_ok) r_data_out <= r_mem[r_rp];
            r_count <= w_count_nxt;
            r_ovf   <= bus.write_en && w_full && !bus.read_en;
            r_udf   <= bus.read_en && w_empty;
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_empty = r_count <= CW'(AEMPTY_THRESH);
    assign bus.almost_full  = r_count >= CW'(AFULL_THRESH);
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: scoreboard bench for a depth-4 instance plus a depth-16 threshold instance.
module tb_fifo_sync_flags;
    logic clk = 0;
    logic rstN = 0;
    int checks = 0;
    int failures = 0;

    fifo_sync_flags_if #(.FIFO_WIDTH(32), .FIFO_DEPTH(4))  b4 ();
    fifo_sync_flags_if #(.FIFO_WIDTH(32), .FIFO_DEPTH(16)) b16 ();

    fifo_sync_flags #(.FIFO_WIDTH(32), .FIFO_DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1))
        dut4 (.clk(clk), .rstN(rstN), .bus(b4));
    fifo_sync_flags #(.FIFO_WIDTH(32), .FIFO_DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4))
        dut16 (.clk(clk), .rstN(rstN), .bus(b16));

    always #5 clk = ~clk;

    logic [31:0] mq [$];
    logic [31:0] md = 0;
    bit movf = 0, mudf = 0;

    // Drive one cycle on the depth-4 FIFO and advance the reference model.
    task automatic step4(input bit we, input bit re, input logic [31:0] d);
        bit f, e;
        b4.write_en = we;
        b4.read_en  = re;
        b4.data_in  = d;
        f = mq.size() == 4;
        e = mq.size() == 0;
        movf = we && f && !re;
        mudf = re && e;
        if (re && !e) md = mq.pop_front();
        if (we && (!f || re)) mq.push_back(d);
        @(posedge clk); #1;
        b4.write_en = 0;
        b4.read_en  = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b4.count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", b4.count); end
        checks++; if (b4.empty !== 1'b1 || b4.almost_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b/%b exp=1/1", b4.empty, b4.almost_empty); end
        checks++; if (b4.full !== 1'b0 || b4.almost_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b/%b exp=0/0", b4.full, b4.almost_full); end
        checks++; if (b4.data_out !== 32'h0 || b4.overflow !== 1'b0 || b4.underflow !== 1'b0) begin failures++; $display("FAIL rst_out got=%h/%b/%b exp=0/0/0", b4.data_out, b4.overflow, b4.underflow); end
        checks++; if (b16.empty !== 1'b1 || b16.almost_empty !== 1'b1 || b16.almost_full !== 1'b0) begin failures++; $display("FAIL rst16_flags got=%b%b%b exp=110", b16.empty, b16.almost_empty, b16.almost_full); end
        @(negedge clk); rstN = 1;
        @(posedge clk); #1;
        step4(1, 0, 32'h11); step4(1, 0, 32'h22); step4(1, 0, 32'h33);
        step4(0, 1, 0);
        rstN = 0; #1;
        mq.delete(); md = 0; movf = 0; mudf = 0;
        checks++; if (b4.count !== 3'd0 || b4.empty !== 1'b1) begin failures++; $display("FAIL rst_mid_count got=%0d/%b exp=0/1", b4.count, b4.empty); end
        checks++; if (b4.data_out !== 32'h0) begin failures++; $display("FAIL rst_mid_dout got=%h exp=0", b4.data_out); end
        @(negedge clk); rstN = 1;
        @(posedge clk); #1;
        step4(1, 0, 32'hA5);
        step4(0, 1, 0);
        checks++; if (b4.data_out !== 32'hA5) begin failures++; $display("FAIL rst_after_dout got=%h exp=a5", b4.data_out); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) step4(1, 0, 32'(i));
        checks++; if (b4.full !== 1'b1 || b4.count !== 3'd4) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/4", b4.full, b4.count); end
        step4(1, 0, 32'h5);
        checks++; if (b4.overflow !== 1'b1 || b4.count !== 3'd4) begin failures++; $display("FAIL ovf_pulse got=%b/%0d exp=1/4", b4.overflow, b4.count); end
        step4(0, 0, 0);
        checks++; if (b4.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", b4.overflow); end
        for (int i = 1; i <= 4; i++) begin
            step4(0, 1, 0);
            checks++; if (b4.data_out !== 32'(i)) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", i, b4.data_out, i); end
        end
        checks++; if (b4.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", b4.empty); end
        for (int r = 0; r < 3; r++) begin
            step4(1, 0, 32'h100 + 32'(r * 8));
            for (int k = 1; k < 6; k++) begin
                step4(1, 1, 32'h100 + 32'(r * 8 + k));
                checks++; if (b4.data_out !== md) begin failures++; $display("FAIL wrap_r%0d_%0d got=%h exp=%h", r, k, b4.data_out, md); end
            end
            step4(0, 1, 0);
            checks++; if (b4.data_out !== md || b4.empty !== 1'b1) begin failures++; $display("FAIL wrap_end_r%0d got=%h/%b exp=%h/1", r, b4.data_out, b4.empty, md); end
        end
    endtask

    task automatic test_simul_full();
        for (int i = 1; i <= 4; i++) step4(1, 0, 32'(i));
        step4(1, 1, 32'h9);
        checks++; if (b4.data_out !== 32'h1 || b4.count !== 3'd4 || b4.overflow !== 1'b0) begin failures++; $display("FAIL simfull got=%h/%0d/%b exp=1/4/0", b4.data_out, b4.count, b4.overflow); end
        foreach (mq[j]) ;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_d;
            exp_d = (i == 3) ? 32'h9 : 32'(i + 2);
            step4(0, 1, 0);
            checks++; if (b4.data_out !== exp_d) begin failures++; $display("FAIL simfull_drain_%0d got=%h exp=%h", i, b4.data_out, exp_d); end
        end
    endtask

    task automatic test_simul_empty();
        logic [31:0] prev;
        prev = b4.data_out;
        step4(1, 1, 32'h7);
        checks++; if (b4.underflow !== 1'b1 || b4.count !== 3'd1 || b4.data_out !== prev) begin failures++; $display("FAIL simempty got=%b/%0d/%h exp=1/1/%h", b4.underflow, b4.count, b4.data_out, prev); end
        step4(0, 1, 0);
        checks++; if (b4.data_out !== 32'h7 || b4.underflow !== 1'b0) begin failures++; $display("FAIL simempty_read got=%h/%b exp=7/0", b4.data_out, b4.underflow); end
    endtask

    task automatic test_thresholds();
        for (int k = 1; k <= 16; k++) begin
            b16.write_en = 1; b16.read_en = 0; b16.data_in = 32'(k);
            @(posedge clk); #1;
            checks++; if (b16.count !== 5'(k) || b16.almost_empty !== (k <= 4) || b16.almost_full !== (k >= 12)) begin failures++; $display("FAIL thr_up_%0d got=%0d/%b/%b exp=%0d/%b/%b", k, b16.count, b16.almost_empty, b16.almost_full, k, k <= 4, k >= 12); end
        end
        checks++; if (b16.full !== 1'b1) begin failures++; $display("FAIL thr_full got=%b exp=1", b16.full); end
        for (int i = 1; i <= 16; i++) begin
            b16.write_en = 0; b16.read_en = 1;
            @(posedge clk); #1;
            checks++; if (b16.data_out !== 32'(i) || b16.count !== 5'(16 - i) || b16.almost_empty !== (16 - i <= 4) || b16.almost_full !== (16 - i >= 12)) begin failures++; $display("FAIL thr_dn_%0d got=%h/%0d/%b/%b exp=%h/%0d", i, b16.data_out, b16.count, b16.almost_empty, b16.almost_full, i, 16 - i); end
        end
        b16.read_en = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            step4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            checks++; if (b4.count !== 3'(mq.size())) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, b4.count, mq.size()); end
            checks++; if (b4.data_out !== md) begin failures++; $display("FAIL rand_dout c=%0d got=%h exp=%h", c, b4.data_out, md); end
            checks++; if (b4.empty !== (mq.size() == 0) || b4.full !== (mq.size() == 4)) begin failures++; $display("FAIL rand_ef c=%0d got=%b%b size=%0d", c, b4.empty, b4.full, mq.size()); end
            checks++; if (b4.almost_empty !== (mq.size() <= 1) || b4.almost_full !== (mq.size() >= 3)) begin failures++; $display("FAIL rand_almost c=%0d got=%b%b size=%0d", c, b4.almost_empty, b4.almost_full, mq.size()); end
            checks++; if (b4.overflow !== movf || b4.underflow !== mudf) begin failures++; $display("FAIL rand_err c=%0d got=%b%b exp=%b%b", c, b4.overflow, b4.underflow, movf, mudf); end
        end
    endtask

    initial begin
        b4.write_en = 0; b4.read_en = 0; b4.data_in = 0;
        b16.write_en = 0; b16.read_en = 0; b16.data_in = 0;
        test_reset();
        test_fill_drain();
        test_simul_full();
        test_simul_empty();
        test_thresholds();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
